cpu_control_unit: RTL and testbench

Multi-cycle controller for the ECE176 CPU datapath. It sequences fetch, decode, execute and write-back by driving the datapath's memory, mux, ALU and register-write controls, and it owns the 13-bit program counter. It consumes the decoded opcode, the BEQ flag and the branch target returned by the datapath, and the memory completion strobe. It sits beside the datapath at CPU top level and is the only source of the datapath's control inputs.

---
 rtl/cpu_ctrl_pkg.sv | 49 ++++
 rtl/mem_wait_timer.sv | 48 ++++
 rtl/cpu_control_unit.sv | 138 +++++++++++++
 tb/tb_cpu_control_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the ECE176 multi-cycle control unit: opcodes, ALU
// encodings, FSM state type and the opcode-to-ALU-control decode.
package cpu_ctrl_pkg;

    localparam int unsigned PC_W = 13;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_BEQ  = 3'b101;
    localparam logic [2:0] OP_NOP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StWriteback = 3'd3,
        StHalted    = 3'd4,
        StFault     = 3'd5
    } ctrl_state_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       instruction_type;
    } alu_ctrl_t;

    // NOP and HALT fall through to the idle value (ADD, register operand).
    function automatic alu_ctrl_t decode_alu_ctrl(input logic [2:0] op);
        alu_ctrl_t c;
        c.alu_op           = ALU_ADD;
        c.instruction_type = 1'b1;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: c.alu_op = op;
            OP_ADDI: c.instruction_type = 1'b0;
            OP_BEQ:  c.alu_op = ALU_SUB;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Down-counter bounding how long FETCH waits for memory. Armed by start,
// disarmed by done; expired flags that Timeout cycles passed without done.
module mem_wait_timer #(
    parameter int unsigned Timeout = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic done,
    output logic expired
);

    localparam int unsigned CntW    = (Timeout > 1) ? $clog2(Timeout) : 1;
    localparam int unsigned LoadVal = (Timeout > 0) ? Timeout - 1 : 0;
    localparam logic [CntW-1:0] Load = CntW'(LoadVal);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            armed_q, armed_d;

    // Reset lands the FSM in FETCH, so the timer comes out of reset armed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= Load;
            armed_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (start) begin
            cnt_d   = Load;
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (done) begin
                armed_d = 1'b0;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    assign expired = (Timeout != 0) && armed_q && (cnt_q == '0);

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK controller for the ECE176 CPU.
// Owns the program counter and drives every datapath control input.
module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned     MEM_TIMEOUT = 15,
    parameter logic [PC_W-1:0] RESET_PC    = 13'd0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      opcode,
    input  logic            beq,
    input  logic [PC_W-1:0] new_pc,
    input  logic            mem_done,
    output logic [PC_W-1:0] pc,
    output logic            read,
    output logic            write,
    output logic            instruction,
    output logic            instruction_type,
    output logic [2:0]      alu_op,
    output logic            reg_write,
    output logic            halted,
    output logic            fault
);

    ctrl_state_e     state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      op_q, op_d;
    logic            timer_start;
    logic            timer_expired;
    alu_ctrl_t       live_ctrl;
    alu_ctrl_t       held_ctrl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            op_q    <= OP_ADD;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        unique case (state_q)
            StFetch: begin
                // A completion on the expiry edge still wins.
                if (mem_done) begin
                    state_d = StDecode;
                end else if (timer_expired) begin
                    state_d = StFault;
                end
            end
            StDecode: begin
                op_d = opcode;
                case (opcode)
                    OP_NOP: begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = StFetch;
                    end
                    OP_HALT: state_d = StHalted;
                    default: state_d = StExecute;
                endcase
            end
            StExecute: begin
                if (op_q == OP_BEQ) begin
                    pc_d    = beq ? new_pc : pc_q + PC_W'(1);
                    state_d = StFetch;
                end else begin
                    state_d = StWriteback;
                end
            end
            StWriteback: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = StFetch;
            end
            StHalted, StFault: ;
            default: state_d = StFetch;
        endcase
    end

    assign timer_start = (state_d == StFetch) && (state_q != StFetch);

    mem_wait_timer #(
        .Timeout (MEM_TIMEOUT)
    ) u_fetch_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (timer_start),
        .done    (mem_done),
        .expired (timer_expired)
    );

    assign live_ctrl = decode_alu_ctrl(opcode);
    assign held_ctrl = decode_alu_ctrl(op_q);

    always_comb begin
        read             = 1'b0;
        instruction      = 1'b0;
        reg_write        = 1'b0;
        halted           = 1'b0;
        fault            = 1'b0;
        alu_op           = ALU_ADD;
        instruction_type = 1'b1;
        unique case (state_q)
            // Gated by reset so the fetch request stays low while reset is held.
            StFetch: begin
                read        = reset;
                instruction = reset;
            end
            StDecode: begin
                alu_op           = live_ctrl.alu_op;
                instruction_type = live_ctrl.instruction_type;
            end
            StExecute: begin
                alu_op           = held_ctrl.alu_op;
                instruction_type = held_ctrl.instruction_type;
            end
            StWriteback: begin
                alu_op           = held_ctrl.alu_op;
                instruction_type = held_ctrl.instruction_type;
                reg_write        = 1'b1;
            end
            StHalted: halted = 1'b1;
            StFault:  fault  = 1'b1;
            default: ;
        endcase
    end

    assign write = 1'b0;
    assign pc    = pc_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: vector table, directed corner
// sequences and random instructions against an instruction-level model.
module tb_cpu_control_unit;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset, reset_w;
    logic [2:0]  opcode;
    logic        beq;
    logic [12:0] new_pc;
    logic        mem_done, mem_done_w;

    logic [12:0] pc, pc_w;
    logic        read, write, instruction, instruction_type, reg_write, halted, fault;
    logic        read_w, write_w, instruction_w, instruction_type_w, reg_write_w;
    logic        halted_w, fault_w;
    logic [2:0]  alu_op, alu_op_w;

    always #5 clk = ~clk;

    cpu_control_unit #(.MEM_TIMEOUT(15), .RESET_PC(13'd0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .beq(beq), .new_pc(new_pc),
        .mem_done(mem_done), .pc(pc), .read(read), .write(write),
        .instruction(instruction), .instruction_type(instruction_type), .alu_op(alu_op),
        .reg_write(reg_write), .halted(halted), .fault(fault)
    );

    cpu_control_unit #(.MEM_TIMEOUT(0), .RESET_PC(13'd8191)) dut_w (
        .clk(clk), .reset(reset_w), .opcode(opcode), .beq(beq), .new_pc(new_pc),
        .mem_done(mem_done_w), .pc(pc_w), .read(read_w), .write(write_w),
        .instruction(instruction_w), .instruction_type(instruction_type_w), .alu_op(alu_op_w),
        .reg_write(reg_write_w), .halted(halted_w), .fault(fault_w)
    );

    int total = 0;
    int bad   = 0;
    logic [12:0] m_pc;

    typedef struct {
        logic [2:0]  op;
        int          dly;
        logic        b;
        logic [12:0] tgt;
        int          cyc;
        int          rw;
        logic [12:0] pc_after;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] obs_main();
        return {9'b0, read, write, instruction, reg_write, alu_op, instruction_type,
                halted, fault, pc};
    endfunction

    function automatic logic [31:0] exp_obs(input logic rd, input logic rw,
                                            input logic [2:0] alu, input logic it,
                                            input logic h, input logic f,
                                            input logic [12:0] p);
        return {9'b0, rd, 1'b0, rd, rw, alu, it, h, f, p};
    endfunction

    // {alu_op, instruction_type} straight from the opcode table.
    function automatic logic [3:0] spec_ctl(input logic [2:0] op);
        if (op < 3'd4) return {op, 1'b1};
        if (op == 3'd4) return 4'b0000;
        if (op == 3'd5) return 4'b0011;
        return 4'b0001;
    endfunction

    task automatic exp_cycle(input string name, input logic rd, input logic rw,
                             input logic [3:0] ctl, input logic h, input logic f,
                             input logic [12:0] p);
        #1;
        check(name, obs_main(), exp_obs(rd, rw, ctl[3:1], ctl[0], h, f, p));
        @(negedge clk);
    endtask

    // One instruction against the model; starts and ends on a falling edge.
    task automatic exec_chk(input logic [2:0] op, input int d, input logic b,
                            input logic [12:0] tgt);
        logic [3:0] ctl;
        ctl    = spec_ctl(op);
        opcode = op;
        beq    = b;
        new_pc = tgt;
        for (int k = 0; k <= d; k++) begin
            mem_done = (k == d);
            exp_cycle("fetch", 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, m_pc);
        end
        mem_done = 1'($urandom_range(0, 1));
        exp_cycle("decode", 1'b0, 1'b0, ctl, 1'b0, 1'b0, m_pc);
        if (op == OP_NOP) begin
            m_pc = m_pc + 13'd1;
            return;
        end
        if (op == OP_HALT) return;
        mem_done = 1'($urandom_range(0, 1));
        exp_cycle("execute", 1'b0, 1'b0, ctl, 1'b0, 1'b0, m_pc);
        if (op == OP_BEQ) begin
            m_pc = b ? tgt : m_pc + 13'd1;
            return;
        end
        mem_done = 1'($urandom_range(0, 1));
        exp_cycle("writeback", 1'b0, 1'b1, ctl, 1'b0, 1'b0, m_pc);
        m_pc = m_pc + 13'd1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc = 0;
        int rw  = 0;
        bit done = 0;
        bit saw_low = 0;
        opcode = v.op;
        beq    = v.b;
        new_pc = v.tgt;
        for (int n = 0; n < 60 && !done; n++) begin
            mem_done = (n >= v.dly);
            #1;
            if (halted || (saw_low && read)) begin
                done = 1;
            end else begin
                if (!read) saw_low = 1;
                cyc++;
                if (reg_write) rw++;
                @(negedge clk);
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL vec%0d timeout: got no return to fetch, expected one", idx);
        end
        check($sformatf("vec%0d cycles", idx), 32'(cyc), 32'(v.cyc));
        check($sformatf("vec%0d reg_write", idx), 32'(rw), 32'(v.rw));
        check($sformatf("vec%0d pc", idx), 32'(pc), 32'(v.pc_after));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        mem_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_pc  = 13'd0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{OP_ADD,  0,  1'b0, 13'd0,    4,  1, 13'd1};
        vecs[1]  = '{OP_ADDI, 3,  1'b0, 13'd0,    7,  1, 13'd2};
        vecs[2]  = '{OP_BEQ,  0,  1'b1, 13'd100,  3,  0, 13'd100};
        vecs[3]  = '{OP_BEQ,  0,  1'b0, 13'd55,   3,  0, 13'd101};
        vecs[4]  = '{OP_SUB,  1,  1'b0, 13'd0,    5,  1, 13'd102};
        vecs[5]  = '{OP_NOP,  0,  1'b0, 13'd0,    2,  0, 13'd103};
        vecs[6]  = '{OP_AND,  14, 1'b0, 13'd0,    18, 1, 13'd104};
        vecs[7]  = '{OP_OR,   2,  1'b0, 13'd0,    6,  1, 13'd105};
        vecs[8]  = '{OP_BEQ,  2,  1'b1, 13'd8191, 5,  0, 13'd8191};
        vecs[9]  = '{OP_NOP,  0,  1'b0, 13'd0,    2,  0, 13'd0};
        vecs[10] = '{OP_NOP,  4,  1'b0, 13'd0,    6,  0, 13'd1};

        reset = 1'b0; reset_w = 1'b0;
        opcode = OP_ADD; beq = 1'b0; new_pc = 13'd0;
        mem_done = 1'b0; mem_done_w = 1'b0;
        m_pc = 13'd0;
        repeat (3) @(negedge clk);
        #1;
        check("reset values", obs_main(), exp_obs(0, 0, 3'b000, 1, 0, 0, 13'd0));
        check("reset pc wrap dut", 32'(pc_w), 32'(13'd8191));

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        do_reset();
        exec_chk(OP_ADD, 0, 1'b0, 13'd0);
        exec_chk(OP_ADDI, 3, 1'b0, 13'd0);
        exec_chk(OP_BEQ, 0, 1'b1, 13'd100);
        exec_chk(OP_BEQ, 1, 1'b0, 13'd100);
        repeat (60) begin
            exec_chk(3'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                     1'($urandom_range(0, 1)), 13'($urandom));
        end

        exec_chk(OP_HALT, 1, 1'b0, 13'd0);
        for (int k = 0; k < 20; k++) begin
            mem_done = 1'($urandom_range(0, 1));
            opcode   = 3'($urandom);
            exp_cycle("halted", 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, m_pc);
        end
        reset = 1'b0;
        #1;
        check("halt async reset", obs_main(), exp_obs(0, 0, 3'b000, 1, 0, 0, 13'd0));
        @(negedge clk);
        reset = 1'b1;
        m_pc  = 13'd0;

        // Reset dropped mid-WRITEBACK, between clock edges.
        opcode   = OP_OR;
        mem_done = 1'b1;
        exp_cycle("wb seq fetch", 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 13'd0);
        exp_cycle("wb seq decode", 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, 13'd0);
        exp_cycle("wb seq execute", 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, 13'd0);
        #1;
        check("wb reg_write before reset", 32'(reg_write), 32'd1);
        reset = 1'b0;
        #1;
        check("wb reg_write dropped", obs_main(), exp_obs(0, 0, 3'b000, 1, 0, 0, 13'd0));
        @(negedge clk);
        reset    = 1'b1;
        mem_done = 1'b0;

        for (int k = 1; k <= 15; k++) begin
            exp_cycle($sformatf("timeout wait %0d", k), 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0,
                      13'd0);
        end
        for (int k = 0; k < 5; k++) begin
            mem_done = 1'($urandom_range(0, 1));
            exp_cycle("fault sticky", 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 13'd0);
        end

        opcode     = OP_NOP;
        reset_w    = 1'b1;
        mem_done_w = 1'b1;
        #1;
        check("wrap fetch", {18'b0, read_w, pc_w}, {18'b0, 1'b1, 13'd8191});
        @(negedge clk);
        mem_done_w = 1'b0;
        #1;
        check("wrap decode", {18'b0, read_w, pc_w}, {18'b0, 1'b0, 13'd8191});
        @(negedge clk);
        #1;
        check("wrap pc", {18'b0, read_w, pc_w}, {18'b0, 1'b1, 13'd0});
        repeat (100) @(negedge clk);
        #1;
        check("no timeout", {17'b0, read_w, fault_w, pc_w}, {17'b0, 1'b1, 1'b0, 13'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
